// File: rtl/qam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_pkg
// Purpose  : Shared definitions for the QAM symbol mapper: modulation mode
//            encoding, mapper FSM state encoding and bits-per-symbol
//            constants for each mode.
// Revision : 1.0 - initial release
// ============================================================================
package qam_pkg;

    // Modulation select as seen on the mode port. The reserved code is
    // handled as QPSK wherever it is decoded.
    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_QAM16 = 2'b10,
        MODE_RSVD  = 2'b11
    } qam_mode_e;

    // Mapper control FSM.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } qam_state_e;

    // Bits consumed from the input word per symbol.
    localparam int C_BITS_BPSK  = 1;
    localparam int C_BITS_QPSK  = 2;
    localparam int C_BITS_QAM16 = 4;

    // Bits per symbol for a raw mode code (reserved falls back to QPSK).
    function automatic int bits_per_symbol(input logic [1:0] mode_code);
        int bits;
        case (qam_mode_e'(mode_code))
            MODE_BPSK:  bits = C_BITS_BPSK;
            MODE_QAM16: bits = C_BITS_QAM16;
            default:    bits = C_BITS_QPSK;
        endcase
        return bits;
    endfunction

endpackage : qam_pkg
`default_nettype wire

// File: rtl/qam_level_map.sv
`default_nettype none
// ============================================================================
// Module   : qam_level_map
// Purpose  : Combinational constellation mapper. Converts up to four symbol
//            bits into signed I/Q levels for BPSK, QPSK or 16-QAM.
// Ports    : i_mode     - modulation select (qam_mode_e encoding)
//            i_sym_bits - symbol bits, b0 in bit 0 (unused bits ignored)
//            o_i_level  - signed in-phase level
//            o_q_level  - signed quadrature level
// Config   : QAM_GRAY_EN - when defined, 16-QAM per-axis levels use Gray
//            coding (00,01,11,10 -> -3A,-A,+A,+3A) instead of natural binary.
// Revision : 1.0 - initial release
// ============================================================================
module qam_level_map
    import qam_pkg::*;
#(
    parameter int IQ_W = 16,
    parameter int AMP  = 8192
) (
    input  logic [1:0]             i_mode,
    input  logic [3:0]             i_sym_bits,
    output logic signed [IQ_W-1:0] o_i_level,
    output logic signed [IQ_W-1:0] o_q_level
);

    localparam logic signed [IQ_W-1:0] C_POS1 = IQ_W'(AMP);
    localparam logic signed [IQ_W-1:0] C_NEG1 = IQ_W'(-AMP);
    localparam logic signed [IQ_W-1:0] C_POS3 = IQ_W'(3 * AMP);
    localparam logic signed [IQ_W-1:0] C_NEG3 = IQ_W'(-3 * AMP);

    // One 16-QAM axis: two bits select one of four amplitude levels.
    function automatic logic signed [IQ_W-1:0] qam16_level(input logic [1:0] b);
        logic signed [IQ_W-1:0] lvl;
        lvl = C_NEG3;
        case (b)
`ifdef QAM_GRAY_EN
            2'b00: lvl = C_NEG3;
            2'b01: lvl = C_NEG1;
            2'b11: lvl = C_POS1;
            2'b10: lvl = C_POS3;
`else
            2'b00: lvl = C_NEG3;
            2'b01: lvl = C_NEG1;
            2'b10: lvl = C_POS1;
            2'b11: lvl = C_POS3;
`endif
            default: lvl = C_NEG3;
        endcase
        return lvl;
    endfunction

    always_comb begin
        o_i_level = '0;
        o_q_level = '0;
        case (qam_mode_e'(i_mode))
            MODE_BPSK: begin
                o_i_level = i_sym_bits[0] ? C_NEG1 : C_POS1;
                o_q_level = '0;
            end
            MODE_QAM16: begin
                o_i_level = qam16_level(i_sym_bits[1:0]);
                o_q_level = qam16_level(i_sym_bits[3:2]);
            end
            default: begin
                // QPSK and the reserved code: a 0 bit is +A, a 1 bit is -A.
                o_i_level = i_sym_bits[0] ? C_NEG1 : C_POS1;
                o_q_level = i_sym_bits[1] ? C_NEG1 : C_POS1;
            end
        endcase
    end

endmodule : qam_level_map
`default_nettype wire

// File: rtl/qam_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module   : qam_symbol_mapper
// Purpose  : Accepts DATA_W-bit words and emits them as I/Q samples, LSB
//            first, k = 1/2/4 bits per symbol (BPSK/QPSK/16-QAM), each symbol
//            held for SPS cycles. Back-to-back words stream without gaps.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous, active-high
//            mode      - 00 BPSK, 01 QPSK, 10 16-QAM, 11 treated as QPSK
//            in_data   - word to modulate, latched with mode on transfer
//            in_valid  - in_data valid
//            in_ready  - word accepted this cycle when in_valid is high
//            i_out     - signed in-phase sample (0 when out_valid is low)
//            q_out     - signed quadrature sample (0 when out_valid is low)
//            out_valid - i_out/q_out carry a sample
// Config   : QAM_GRAY_EN - Gray-coded 16-QAM levels (see qam_level_map).
// Revision : 1.0 - initial release
// ============================================================================
module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IQ_W   = 16,
    parameter int SPS    = 4,
    parameter int AMP    = 8192
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out,
    output logic                   out_valid
);

    // ---------------------------------------------------------------- checks
    if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_chk_data_w
        $error("qam_symbol_mapper: DATA_W must be a multiple of 4 and >= 4");
    end
    if (SPS < 1) begin : g_chk_sps
        $error("qam_symbol_mapper: SPS must be >= 1");
    end
    if ((longint'(3) * longint'(AMP)) > ((longint'(1) << (IQ_W - 1)) - 1)) begin : g_chk_amp
        $error("qam_symbol_mapper: 3*AMP does not fit in signed IQ_W");
    end

    // ------------------------------------------------------------ constants
    localparam int C_SYM_W = $clog2(DATA_W + 1);
    localparam int C_SMP_W = (SPS > 1) ? $clog2(SPS) : 1;

    localparam logic [C_SMP_W-1:0] C_SMP_LAST       = C_SMP_W'(SPS - 1);
    localparam logic [C_SYM_W-1:0] C_SYM_LAST_BPSK  = C_SYM_W'(DATA_W / C_BITS_BPSK - 1);
    localparam logic [C_SYM_W-1:0] C_SYM_LAST_QPSK  = C_SYM_W'(DATA_W / C_BITS_QPSK - 1);
    localparam logic [C_SYM_W-1:0] C_SYM_LAST_QAM16 = C_SYM_W'(DATA_W / C_BITS_QAM16 - 1);

    // ------------------------------------------------------------ registers
    qam_state_e             r_state;
    logic [1:0]             r_mode;
    logic [DATA_W-1:0]      r_word;      // current symbol sits in the low bits
    logic [C_SMP_W-1:0]     r_smp_cnt;
    logic [C_SYM_W-1:0]     r_sym_cnt;
    logic                   r_out_valid;
    logic signed [IQ_W-1:0] r_i;
    logic signed [IQ_W-1:0] r_q;

    // ---------------------------------------------------------- comb decode
    logic [C_SYM_W-1:0]     w_sym_last;
    logic [DATA_W-1:0]      w_next_word;
    logic                   w_word_end;
    logic                   w_xfer;
    logic [1:0]             w_map_mode;
    logic [3:0]             w_map_bits;
    logic signed [IQ_W-1:0] w_i_level;
    logic signed [IQ_W-1:0] w_q_level;

    // Last symbol index and next-symbol alignment depend on the latched mode.
    always_comb begin
        w_sym_last  = C_SYM_LAST_QPSK;
        w_next_word = r_word >> C_BITS_QPSK;
        case (qam_mode_e'(r_mode))
            MODE_BPSK: begin
                w_sym_last  = C_SYM_LAST_BPSK;
                w_next_word = r_word >> C_BITS_BPSK;
            end
            MODE_QAM16: begin
                w_sym_last  = C_SYM_LAST_QAM16;
                w_next_word = r_word >> C_BITS_QAM16;
            end
            default: begin
                w_sym_last  = C_SYM_LAST_QPSK;
                w_next_word = r_word >> C_BITS_QPSK;
            end
        endcase
    end

    assign w_word_end = (r_state == ST_EMIT) &&
                        (r_smp_cnt == C_SMP_LAST) &&
                        (r_sym_cnt == w_sym_last);

    // Ready in IDLE and on the final sample of a word, so a waiting word
    // follows on the next cycle without a bubble.
    assign in_ready = (r_state == ST_IDLE) || w_word_end;
    assign w_xfer   = in_valid && in_ready;

    // A new word is mapped straight from the inputs so its first sample
    // appears one cycle after the transfer; otherwise map the next symbol.
    assign w_map_mode = w_xfer ? mode         : r_mode;
    assign w_map_bits = w_xfer ? in_data[3:0] : w_next_word[3:0];

    qam_level_map #(
        .IQ_W (IQ_W),
        .AMP  (AMP)
    ) u_level_map (
        .i_mode     (w_map_mode),
        .i_sym_bits (w_map_bits),
        .o_i_level  (w_i_level),
        .o_q_level  (w_q_level)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= '0;
            r_word      <= '0;
            r_smp_cnt   <= '0;
            r_sym_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_i         <= '0;
            r_q         <= '0;
        end else if (w_xfer) begin
            r_state     <= ST_EMIT;
            r_mode      <= mode;
            r_word      <= in_data;
            r_smp_cnt   <= '0;
            r_sym_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_i         <= w_i_level;
            r_q         <= w_q_level;
        end else if (r_state == ST_EMIT) begin
            if (w_word_end) begin
                r_state     <= ST_IDLE;
                r_smp_cnt   <= '0;
                r_sym_cnt   <= '0;
                r_out_valid <= 1'b0;
                r_i         <= '0;
                r_q         <= '0;
            end else if (r_smp_cnt == C_SMP_LAST) begin
                r_smp_cnt <= '0;
                r_sym_cnt <= r_sym_cnt + C_SYM_W'(1);
                r_word    <= w_next_word;
                r_i       <= w_i_level;
                r_q       <= w_q_level;
            end else begin
                r_smp_cnt <= r_smp_cnt + C_SMP_W'(1);
            end
        end
    end

    assign i_out     = r_i;
    assign q_out     = r_q;
    assign out_valid = r_out_valid;

endmodule : qam_symbol_mapper
`default_nettype wire

// File: tb/tb_qam_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_symbol_mapper
// Purpose  : Directed self-checking bench for qam_symbol_mapper with
//            DATA_W=8, IQ_W=16, SPS=4, AMP=8192. Expected samples are
//            hand-derived constellation points. QAM_GRAY_EN selects the
//            Gray-coded 16-QAM expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_symbol_mapper;

    localparam int DATA_W = 8;
    localparam int IQ_W   = 16;
    localparam int SPS    = 4;
    localparam int AMP    = 8192;
    localparam int A1     = 8192;
    localparam int A3     = 24576;

    logic                   clk;
    logic                   reset;
    logic [1:0]             mode;
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IQ_W-1:0] i_out;
    logic signed [IQ_W-1:0] q_out;
    logic                   out_valid;

    int checks   = 0;
    int failures = 0;

    logic signed [31:0] ei [16];
    logic signed [31:0] eq [16];

    qam_symbol_mapper #(
        .DATA_W (DATA_W),
        .IQ_W   (IQ_W),
        .SPS    (SPS),
        .AMP    (AMP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_i"}, $signed(i_out), 0);
        chk({tag, "_idle_q"}, $signed(q_out), 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    // Present one word at a negedge; returns at the negedge after the
    // transfer edge, where the first sample must already be visible.
    // Mode and data are then scrambled to show they are not re-sampled.
    task automatic send(input string tag, input logic [1:0] m, input logic [7:0] d);
        chk({tag, "_ready_before"}, in_ready, 1);
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mode     = ~m;
        in_data  = ~d;
    endtask

    // Check nsym symbols of SPS samples from ei/eq, then the idle state.
    task automatic play(input string tag, input int nsym);
        for (int s = 0; s < nsym; s++) begin
            for (int c = 0; c < SPS; c++) begin
                chk($sformatf("%s_s%0d_c%0d_valid", tag, s, c), out_valid, 1);
                chk($sformatf("%s_s%0d_c%0d_i", tag, s, c), $signed(i_out), ei[s]);
                chk($sformatf("%s_s%0d_c%0d_q", tag, s, c), $signed(q_out), eq[s]);
                chk($sformatf("%s_s%0d_c%0d_ready", tag, s, c), in_ready,
                    ((s == nsym - 1) && (c == SPS - 1)) ? 1 : 0);
                @(negedge clk);
            end
        end
        chk_idle(tag);
    endtask

    int pulses;
    int pulse_cycle;

    initial begin
        reset    = 1'b1;
        mode     = 2'b00;
        in_data  = '0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // QPSK 0xE4
        ei[0] =  A1; eq[0] =  A1;
        ei[1] = -A1; eq[1] =  A1;
        ei[2] =  A1; eq[2] = -A1;
        ei[3] = -A1; eq[3] = -A1;
        send("qpsk_e4", 2'b01, 8'hE4);
        play("qpsk_e4", 4);

        // BPSK 0xA5: bits LSB first 1,0,1,0,0,1,0,1
        ei[0] = -A1; ei[1] =  A1; ei[2] = -A1; ei[3] =  A1;
        ei[4] =  A1; ei[5] = -A1; ei[6] =  A1; ei[7] = -A1;
        for (int k = 0; k < 8; k++) eq[k] = 0;
        send("bpsk_a5", 2'b00, 8'hA5);
        play("bpsk_a5", 8);

        // 16-QAM 0x1B
`ifdef QAM_GRAY_EN
        ei[0] =  A1; eq[0] =  A3;
`else
        ei[0] =  A3; eq[0] =  A1;
`endif
        ei[1] = -A1; eq[1] = -A3;
        send("qam16_1b", 2'b10, 8'h1B);
        play("qam16_1b", 2);

        // Reserved mode behaves as QPSK: 0x02 -> pairs 10,00,00,00
        ei[0] =  A1; eq[0] = -A1;
        ei[1] =  A1; eq[1] =  A1;
        ei[2] =  A1; eq[2] =  A1;
        ei[3] =  A1; eq[3] =  A1;
        send("rsvd_02", 2'b11, 8'h02);
        play("rsvd_02", 4);

        // Back-to-back QPSK words 0xE4 then 0x1B with in_valid held high
        ei[0] =  A1; eq[0] =  A1;
        ei[1] = -A1; eq[1] =  A1;
        ei[2] =  A1; eq[2] = -A1;
        ei[3] = -A1; eq[3] = -A1;
        ei[4] = -A1; eq[4] = -A1;
        ei[5] =  A1; eq[5] = -A1;
        ei[6] = -A1; eq[6] =  A1;
        ei[7] =  A1; eq[7] =  A1;
        pulses      = 0;
        pulse_cycle = 0;
        chk("b2b_ready_before", in_ready, 1);
        mode     = 2'b01;
        in_data  = 8'hE4;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h1B;
        for (int c = 1; c <= 32; c++) begin
            if (c == 17) in_valid = 1'b0;
            chk($sformatf("b2b_c%0d_valid", c), out_valid, 1);
            chk($sformatf("b2b_c%0d_i", c), $signed(i_out), ei[(c - 1) / SPS]);
            chk($sformatf("b2b_c%0d_q", c), $signed(q_out), eq[(c - 1) / SPS]);
            chk($sformatf("b2b_c%0d_ready", c), in_ready, ((c == 16) || (c == 32)) ? 1 : 0);
            if ((c < 32) && (in_ready === 1'b1)) begin
                pulses++;
                pulse_cycle = c;
            end
            @(negedge clk);
        end
        chk("b2b_ready_pulses", pulses, 1);
        chk("b2b_ready_pulse_cycle", pulse_cycle, 16);
        chk_idle("b2b");

        // Reset in cycle 6 of a QPSK 0xE4 word
        ei[0] =  A1; eq[0] =  A1;
        ei[1] = -A1; eq[1] =  A1;
        send("rst_mid", 2'b01, 8'hE4);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("rst_mid_c%0d_i", c), $signed(i_out), ei[(c - 1) / SPS]);
            chk($sformatf("rst_mid_c%0d_q", c), $signed(q_out), eq[(c - 1) / SPS]);
            @(negedge clk);
        end
        chk("rst_mid_c6_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_async_valid", out_valid, 0);
        chk("rst_mid_async_i", $signed(i_out), 0);
        chk("rst_mid_async_q", $signed(q_out), 0);
        chk("rst_mid_async_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst_release");

        // Next word after reset starts from symbol 0: QPSK 0x1B
        ei[0] = -A1; eq[0] = -A1;
        ei[1] =  A1; eq[1] = -A1;
        ei[2] = -A1; eq[2] =  A1;
        ei[3] =  A1; eq[3] =  A1;
        send("rst_next", 2'b01, 8'h1B);
        play("rst_next", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qam_symbol_mapper
`default_nettype wire

// File: doc/qam_symbol_mapper.md
QAM_SYMBOL_MAPPER -- requirements
Module: qam_symbol_mapper

Interface
REQ-001 SHALL have parameter DATA_W, default 8: input word width; multiple of 4, >=4.
REQ-002 SHALL have parameter IQ_W, default 16: signed I/Q sample width.
REQ-003 SHALL have parameter SPS, default 4: output samples per symbol, >=1.
REQ-004 SHALL have parameter AMP, default 8192: unit amplitude A; 3*AMP <= 2^(IQ_W-1)-1, else elaboration error.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port mode, input, 2: 00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved (treated as QPSK).
REQ-008 SHALL have port in_data, input, DATA_W: word to modulate, LSB first.
REQ-009 SHALL have port in_valid, input, 1: in_data valid.
REQ-010 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-011 SHALL have port i_out, output, IQ_W signed: in-phase sample.
REQ-012 SHALL have port q_out, output, IQ_W signed: quadrature sample.
REQ-013 SHALL have port out_valid, output, 1: i_out/q_out carry a sample.

Function
REQ-014 SHALL transfer a word on a rising edge with in_valid && in_ready; in_data and mode latch together; mode changes mid-word are ignored.
REQ-015 SHALL implement FSM IDLE/EMIT: IDLE -> EMIT on transfer; EMIT -> IDLE after the last sample of the last symbol unless a transfer occurs that cycle, in which case EMIT continues with the new word.
REQ-016 SHALL assert in_ready in IDLE and in the last sample cycle of the last symbol of EMIT; deasserted otherwise.
REQ-017 SHALL take k = 1/2/4 bits per symbol (BPSK/QPSK/16-QAM), LSB first, giving DATA_W/k symbols per word.
REQ-018 SHALL hold each symbol for exactly SPS consecutive cycles with out_valid=1; first sample appears the cycle after transfer (latency 1).
REQ-019 SHALL produce back-to-back words with no gap in out_valid.
REQ-020 SHALL map BPSK: b0=0 -> I=+A, b0=1 -> I=-A, Q=0.
REQ-021 SHALL map QPSK: b0 -> I, b1 -> Q; 0 -> +A, 1 -> -A.
REQ-022 SHALL map 16-QAM: b1b0 -> I, b3b2 -> Q; 00 -3A, 01 -A, 10 +A, 11 +3A (natural binary).
REQ-023 SHALL drive i_out=q_out=0 whenever out_valid=0.
REQ-024 SHALL keep a sample counter 0..SPS-1 and symbol counter 0..DATA_W/k-1, both wrapping to 0 at word end.

Reset
REQ-025 SHALL on reset (any time, incl. mid-symbol) immediately force state IDLE, counters 0, out_valid=0, i_out=q_out=0, in_ready=1; the partial word is discarded.

Configuration
REQ-026 SHALL, with QAM_GRAY_EN defined, map 16-QAM levels Gray-coded: 00 -3A, 01 -A, 11 +A, 10 +3A; BPSK/QPSK unchanged.
REQ-027 SHALL, without QAM_GRAY_EN, use the natural-binary mapping of REQ-022.

Structure
REQ-028 SHALL place mode enum, FSM state enum and bits-per-mode constants in shared package qam_pkg.
REQ-029 SHALL place symbol-to-level mapping in combinational sub-module qam_level_map (inputs: mode, symbol bits; outputs: I, Q).

Verification (DATA_W=8, IQ_W=16, SPS=4, AMP=8192)
REQ-030 SHALL verify QPSK 8'hE4 -> (I,Q) = (8192,8192),(-8192,8192),(8192,-8192),(-8192,-8192), 4 cycles each, 16 cycles out_valid.
REQ-031 SHALL verify BPSK 8'hA5 -> I = -8192,8192,-8192,8192,8192,-8192,8192,-8192, Q=0, 32 cycles.
REQ-032 SHALL verify 16-QAM 8'h1B -> (24576,8192) then (-8192,-24576); with QAM_GRAY_EN -> (8192,24576) then (-8192,-24576).
REQ-033 SHALL verify two QPSK words with in_valid held high -> out_valid continuous for 32 cycles, in_ready pulses once at cycle 16.
REQ-034 SHALL verify reset asserted in cycle 6 of a QPSK word -> outputs 0 and out_valid 0 immediately; after release in_ready=1 and next word starts at symbol 0.
